collision_det_multi: RTL and testbench

Parametrised successor to the single-pair collision checker. It tests the bird AABB against the ground, the ceiling and up to NUM_PIPES pipe columns. Each evaluation runs once per frame_tick, scanning pipes sequentially over one pipe per cycle, which gives a bounded-latency, timing-friendly datapath. It reports a sticky collision flag with cause, pipe index, a grace window after restart, and an overrun flag. It sits between pipe_gen/bird_ctrl and the game-state FSM.

---
 rtl/collision_det_multi.sv | 218 +++++++++++++++++++++
 tb/tb_collision_det_multi.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_det_multi.sv
// Bird-vs-world collision checker: ground, ceiling and NUM_PIPES pipe columns,
// one pipe per cycle, with sticky cause/index, grace window and overrun flag.
module collision_det_multi #(
    parameter int NUM_PIPES    = 4,
    parameter int COORD_W      = 12,
    parameter int BIRD_W       = 50,
    parameter int BIRD_H       = 35,
    parameter int PIPE_W       = 80,
    parameter int PIPE_GAP_H   = 220,
    parameter int GROUND_Y     = 668,
    parameter int HIT_MARGIN   = 5,
    parameter int GRACE_FRAMES = 30,
    localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         frame_tick,
    input  logic                         clear,
    input  logic [COORD_W-1:0]           bird_x,
    input  logic [COORD_W-1:0]           bird_y,
    input  logic [NUM_PIPES*COORD_W-1:0] pipe_x,
    input  logic [NUM_PIPES*COORD_W-1:0] pipe_gap_y,
    input  logic [NUM_PIPES-1:0]         pipe_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         collision,
    output logic [1:0]                   hit_cause,
    output logic [IDX_W-1:0]             hit_idx,
    output logic                         overrun,
    output logic                         grace
);

    localparam int SW = COORD_W + 2;
    localparam int GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

    localparam logic signed [SW-1:0] BIRD_W_S   = SW'(BIRD_W);
    localparam logic signed [SW-1:0] BIRD_H_S   = SW'(BIRD_H);
    localparam logic signed [SW-1:0] PIPE_W_S   = SW'(PIPE_W);
    localparam logic signed [SW-1:0] HALF_GAP_S = SW'(PIPE_GAP_H / 2);
    localparam logic signed [SW-1:0] MARGIN_S   = SW'(HIT_MARGIN);
    localparam logic signed [SW-1:0] GROUND_S   = SW'(GROUND_Y - BIRD_H);
    localparam logic [IDX_W-1:0]     LAST_I     = IDX_W'(NUM_PIPES - 1);
    localparam logic [GW-1:0]        GRACE_INIT = GW'(GRACE_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESOLVE
    } state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             scan_i_q, scan_i_d;
    logic [COORD_W-1:0]           snap_bx_q, snap_bx_d;
    logic [COORD_W-1:0]           snap_by_q, snap_by_d;
    logic [NUM_PIPES*COORD_W-1:0] snap_px_q, snap_px_d;
    logic [NUM_PIPES*COORD_W-1:0] snap_gy_q, snap_gy_d;
    logic [NUM_PIPES-1:0]         snap_v_q, snap_v_d;
    logic                         found_q, found_d;
    logic [IDX_W-1:0]             fidx_q, fidx_d;
    logic                         done_q, done_d;
    logic                         coll_q, coll_d;
    logic [1:0]                   cause_q, cause_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         ovr_q, ovr_d;
    logic [GW-1:0]                gcnt_q, gcnt_d;

    logic [COORD_W-1:0]   cur_px, cur_gy;
    logic                 cur_v;
    logic signed [SW-1:0] bx_s, by_s, px_s, gy_s;
    logic                 x_ovl, y_hit, pipe_hit;
    logic                 gnd_hit, ceil_hit, pipe_eff, grace_on;

    // Datapath works only on the snapshot so inputs may move during a scan.
    always_comb begin
        cur_px   = snap_px_q[32'(scan_i_q) * COORD_W +: COORD_W];
        cur_gy   = snap_gy_q[32'(scan_i_q) * COORD_W +: COORD_W];
        cur_v    = snap_v_q[scan_i_q];
        bx_s     = $signed({2'b00, snap_bx_q});
        by_s     = $signed({2'b00, snap_by_q});
        px_s     = $signed({2'b00, cur_px});
        gy_s     = $signed({2'b00, cur_gy});
        x_ovl    = (bx_s + BIRD_W_S > px_s) && (bx_s < px_s + PIPE_W_S);
        y_hit    = (by_s + MARGIN_S < gy_s - HALF_GAP_S) ||
                   (by_s + BIRD_H_S - MARGIN_S > gy_s + HALF_GAP_S);
        pipe_hit = cur_v && x_ovl && y_hit;
        grace_on = (gcnt_q != '0);
        gnd_hit  = (by_s >= GROUND_S);
        ceil_hit = (snap_by_q == '0);
        pipe_eff = found_q && !grace_on;
    end

    always_comb begin
        state_d   = state_q;
        scan_i_d  = scan_i_q;
        snap_bx_d = snap_bx_q;
        snap_by_d = snap_by_q;
        snap_px_d = snap_px_q;
        snap_gy_d = snap_gy_q;
        snap_v_d  = snap_v_q;
        found_d   = found_q;
        fidx_d    = fidx_q;
        done_d    = 1'b0;
        coll_d    = coll_q;
        cause_d   = cause_q;
        idx_d     = idx_q;
        ovr_d     = ovr_q;
        gcnt_d    = gcnt_q;

        unique case (state_q)
            IDLE: begin
                if (frame_tick && enable && !clear) begin
                    snap_bx_d = bird_x;
                    snap_by_d = bird_y;
                    snap_px_d = pipe_x;
                    snap_gy_d = pipe_gap_y;
                    snap_v_d  = pipe_valid;
                    scan_i_d  = '0;
                    found_d   = 1'b0;
                    fidx_d    = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (pipe_hit && !found_q) begin
                    found_d = 1'b1;
                    fidx_d  = scan_i_q;
                end
                if (scan_i_q == LAST_I) begin
                    state_d = RESOLVE;
                end else begin
                    scan_i_d = scan_i_q + 1'b1;
                end
            end
            RESOLVE: begin
                if (!coll_q && (gnd_hit || ceil_hit || pipe_eff)) begin
                    coll_d = 1'b1;
                    if (gnd_hit) begin
                        cause_d = 2'd1;
                        idx_d   = '0;
                    end else if (ceil_hit) begin
                        cause_d = 2'd2;
                        idx_d   = '0;
                    end else begin
                        cause_d = 2'd3;
                        idx_d   = fidx_q;
                    end
                end
                if (grace_on) begin
                    gcnt_d = gcnt_q - 1'b1;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (frame_tick && enable && !clear && state_q != IDLE) begin
            ovr_d = 1'b1;
        end

        // clear overrides everything, including a RESOLVE in the same cycle.
        if (clear) begin
            state_d = IDLE;
            done_d  = 1'b0;
            coll_d  = 1'b0;
            cause_d = 2'd0;
            idx_d   = '0;
            ovr_d   = 1'b0;
            gcnt_d  = GRACE_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            scan_i_q  <= '0;
            snap_bx_q <= '0;
            snap_by_q <= '0;
            snap_px_q <= '0;
            snap_gy_q <= '0;
            snap_v_q  <= '0;
            found_q   <= 1'b0;
            fidx_q    <= '0;
            done_q    <= 1'b0;
            coll_q    <= 1'b0;
            cause_q   <= 2'd0;
            idx_q     <= '0;
            ovr_q     <= 1'b0;
            gcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            scan_i_q  <= scan_i_d;
            snap_bx_q <= snap_bx_d;
            snap_by_q <= snap_by_d;
            snap_px_q <= snap_px_d;
            snap_gy_q <= snap_gy_d;
            snap_v_q  <= snap_v_d;
            found_q   <= found_d;
            fidx_q    <= fidx_d;
            done_q    <= done_d;
            coll_q    <= coll_d;
            cause_q   <= cause_d;
            idx_q     <= idx_d;
            ovr_q     <= ovr_d;
            gcnt_q    <= gcnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign collision = coll_q;
    assign hit_cause = cause_q;
    assign hit_idx   = idx_q;
    assign overrun   = ovr_q;
    assign grace     = grace_on;

endmodule

// File: tb/tb_collision_det_multi.sv
// Scoreboard bench for collision_det_multi: a behavioural model predicts each
// evaluation when the tick is driven; results are compared when done pulses.
module tb_collision_det_multi;

    localparam int NP = 4;
    localparam int CW = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             frame_tick;
    logic             clear;
    logic [CW-1:0]    bird_x;
    logic [CW-1:0]    bird_y;
    logic [NP*CW-1:0] pipe_x;
    logic [NP*CW-1:0] pipe_gap_y;
    logic [NP-1:0]    pipe_valid;
    logic             busy;
    logic             done;
    logic             collision;
    logic [1:0]       hit_cause;
    logic [1:0]       hit_idx;
    logic             overrun;
    logic             grace;

    collision_det_multi #(
        .NUM_PIPES(NP),
        .COORD_W(CW),
        .GRACE_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .frame_tick(frame_tick),
        .clear(clear),
        .bird_x(bird_x),
        .bird_y(bird_y),
        .pipe_x(pipe_x),
        .pipe_gap_y(pipe_gap_y),
        .pipe_valid(pipe_valid),
        .busy(busy),
        .done(done),
        .collision(collision),
        .hit_cause(hit_cause),
        .hit_idx(hit_idx),
        .overrun(overrun),
        .grace(grace)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit coll;
        int cause;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int bx, by;
    int px[NP];
    int gy[NP];
    bit pv[NP];

    bit m_coll;
    int m_cause, m_idx, m_gcnt;

    task automatic apply();
        bird_x = CW'(bx);
        bird_y = CW'(by);
        for (int i = 0; i < NP; i++) begin
            pipe_x[i*CW +: CW]     = CW'(px[i]);
            pipe_gap_y[i*CW +: CW] = CW'(gy[i]);
            pipe_valid[i]          = pv[i];
        end
    endtask

    task automatic set_pipe(input int i, input int x, input int g, input bit v);
        px[i] = x;
        gy[i] = g;
        pv[i] = v;
    endtask

    // Behavioural prediction with plain integer arithmetic (no wrap).
    task automatic model_eval();
        bit   gnd, ceil, ph;
        int   pi;
        exp_t e;
        gnd = (by >= 668 - 35);
        ceil = (by == 0);
        pi = -1;
        for (int i = NP - 1; i >= 0; i--) begin
            if (pv[i] && (bx + 50 > px[i]) && (bx < px[i] + 80) &&
                ((by + 5 < gy[i] - 110) || (by + 35 - 5 > gy[i] + 110)))
                pi = i;
        end
        ph = (pi >= 0) && (m_gcnt == 0);
        if (!m_coll && (gnd || ceil || ph)) begin
            m_coll  = 1;
            m_cause = gnd ? 1 : (ceil ? 2 : 3);
            m_idx   = (gnd || ceil) ? 0 : pi;
        end
        if (m_gcnt > 0) m_gcnt--;
        e.coll  = m_coll;
        e.cause = m_cause;
        e.idx   = m_idx;
        sb.push_back(e);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_coll  = 0;
        m_cause = 0;
        m_idx   = 0;
        m_gcnt  = 2;
    endtask

    // mode 0: plain, 1: scramble inputs during scan, 2: drop enable mid-scan
    task automatic run_tick(input int mode);
        int   cnt;
        bit   got;
        exp_t e;
        model_eval();
        frame_tick = 1'b1;
        cnt = 0;
        got = 0;
        while (cnt < 20 && !got) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                frame_tick = 1'b0;
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_start got %b want 1", busy);
                end
                if (mode == 1) begin
                    bird_y     = '0;
                    pipe_valid = '0;
                    pipe_x     = '0;
                end
                if (mode == 2) enable = 1'b0;
            end
            if (done === 1'b1) got = 1;
        end
        checks++;
        if (!got || cnt != NP + 2) begin
            errors++;
            $display("FAIL done_latency got %0d (seen %0b) want %0d", cnt, got, NP + 2);
        end
        e = sb.pop_front();
        checks++;
        if (collision !== e.coll) begin
            errors++;
            $display("FAIL collision got %b want %b", collision, e.coll);
        end
        checks++;
        if (hit_cause !== 2'(e.cause)) begin
            errors++;
            $display("FAIL hit_cause got %0d want %0d", hit_cause, e.cause);
        end
        checks++;
        if (hit_idx !== 2'(e.idx)) begin
            errors++;
            $display("FAIL hit_idx got %0d want %0d", hit_idx, e.idx);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done %b busy %b want 0 0", done, busy);
        end
        enable = 1'b1;
        apply();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_coll = 0; m_cause = 0; m_idx = 0; m_gcnt = 0;
        checks++;
        if ({busy, done, collision, hit_cause, hit_idx, overrun, grace} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                     {busy, done, collision, hit_cause, hit_idx, overrun, grace});
        end
    endtask

    task automatic test_miss();
        bx = 100; by = 300;
        set_pipe(0, 120, 320, 1);
        for (int i = 1; i < NP; i++) set_pipe(i, 120, 150, 0);
        apply();
        run_tick(0);
        checks++;
        if (collision !== 1'b0) begin
            errors++;
            $display("FAIL miss_no_coll got %b want 0", collision);
        end
    endtask

    task automatic test_pipe_hit();
        gy[0] = 150;
        apply();
        run_tick(1);
        checks++;
        if (collision !== 1'b1 || hit_cause !== 2'd3 || hit_idx !== 2'd0) begin
            errors++;
            $display("FAIL pipe0_hit got %b/%0d/%0d want 1/3/0", collision, hit_cause, hit_idx);
        end
        gy[0] = 320;
        apply();
        run_tick(0);
        checks++;
        if (collision !== 1'b1 || hit_cause !== 2'd3) begin
            errors++;
            $display("FAIL sticky got %b/%0d want 1/3", collision, hit_cause);
        end
    endtask

    task automatic test_priority_grace();
        do_clear();
        checks++;
        if (collision !== 1'b0 || grace !== 1'b1) begin
            errors++;
            $display("FAIL clear_state coll %b grace %b want 0 1", collision, grace);
        end
        bx = 100; by = 633;
        set_pipe(0, 120, 320, 0);
        set_pipe(1, 120, 150, 1);
        set_pipe(2, 120, 150, 0);
        set_pipe(3, 120, 150, 1);
        apply();
        run_tick(0);
        checks++;
        if (hit_cause !== 2'd1) begin
            errors++;
            $display("FAIL ground_prio got %0d want 1", hit_cause);
        end
        do_clear();
        by = 300;
        apply();
        run_tick(0);
        run_tick(2);
        checks++;
        if (collision !== 1'b0 || grace !== 1'b0) begin
            errors++;
            $display("FAIL grace_mask coll %b grace %b want 0 0", collision, grace);
        end
        run_tick(0);
        checks++;
        if (collision !== 1'b1 || hit_cause !== 2'd3 || hit_idx !== 2'd1) begin
            errors++;
            $display("FAIL lowest_idx got %b/%0d/%0d want 1/3/1", collision, hit_cause, hit_idx);
        end
    endtask

    task automatic test_ceiling();
        do_clear();
        by = 0;
        apply();
        run_tick(0);
        checks++;
        if (hit_cause !== 2'd2 || grace !== 1'b1) begin
            errors++;
            $display("FAIL ceiling got cause %0d grace %b want 2 1", hit_cause, grace);
        end
    endtask

    task automatic test_overrun();
        int   ndone, first;
        exp_t e;
        do_clear();
        by = 300;
        set_pipe(1, 120, 320, 1);
        set_pipe(3, 120, 320, 1);
        apply();
        model_eval();
        frame_tick = 1'b1;
        ndone = 0;
        first = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            frame_tick = (c == 2);
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        e = sb.pop_front();
        checks++;
        if (ndone != 1 || first != NP + 2) begin
            errors++;
            $display("FAIL overrun_done count %0d at %0d want 1 at %0d", ndone, first, NP + 2);
        end
        checks++;
        if (overrun !== 1'b1 || collision !== e.coll) begin
            errors++;
            $display("FAIL overrun_flag ovr %b coll %b want 1 %b", overrun, collision, e.coll);
        end
        clear = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        frame_tick = 1'b0;
        m_coll = 0; m_cause = 0; m_idx = 0; m_gcnt = 2;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (busy !== 1'b0 || done !== 1'b0) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone != 0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL clear_tick busy/done cycles %0d ovr %b want 0 0", ndone, overrun);
        end
    endtask

    task automatic test_enable();
        int nact;
        enable = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        nact = 0;
        for (int c = 0; c < 10; c++) begin
            if (busy !== 1'b0 || done !== 1'b0) nact++;
            @(negedge clk);
        end
        enable = 1'b1;
        checks++;
        if (nact != 0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL enable_low active %0d ovr %b want 0 0", nact, overrun);
        end
    endtask

    task automatic test_abort_reset();
        int nact;
        by = 633;
        apply();
        run_tick(0);
        frame_tick = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            frame_tick = 1'b0;
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_coll = 0; m_cause = 0; m_idx = 0; m_gcnt = 2;
        checks++;
        if ({busy, done, collision, hit_cause, hit_idx, overrun} !== 8'd0) begin
            errors++;
            $display("FAIL abort_clear got %b want 0",
                     {busy, done, collision, hit_cause, hit_idx, overrun});
        end
        nact = 0;
        for (int c = 0; c < 10; c++) begin
            if (done !== 1'b0) nact++;
            @(negedge clk);
        end
        checks++;
        if (nact != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d want 0", nact);
        end
        run_tick(0);
        frame_tick = 1'b1;
        repeat (2) begin
            @(negedge clk);
            frame_tick = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, collision, hit_cause, hit_idx, overrun, grace} !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid_scan got %b want 0",
                     {busy, done, collision, hit_cause, hit_idx, overrun, grace});
        end
        rst = 1'b0;
        m_coll = 0; m_cause = 0; m_idx = 0; m_gcnt = 0;
        by = 300;
        gy[1] = 320;
        gy[3] = 320;
        apply();
        run_tick(0);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        frame_tick = 1'b0;
        clear = 1'b0;
        bx = 100; by = 300;
        for (int i = 0; i < NP; i++) set_pipe(i, 0, 0, 0);
        apply();
        @(negedge clk);
        test_reset();
        test_miss();
        test_pipe_hit();
        test_priority_grace();
        test_ceiling();
        test_overrun();
        test_enable();
        test_abort_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
